// File: rtl/pulse_stretch.sv
`default_nettype none
// ============================================================================
// Module      : pulse_stretch
// Description : Stretches a single-cycle trigger into a len-cycle high level,
//               followed by a gap-cycle holdoff, with optional retriggering.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_stretch #(
    parameter int CNT_W  = 8,
    parameter bit RETRIG = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic [CNT_W-1:0] len,
    input  logic [CNT_W-1:0] gap,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic             miss
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             done_d;
    logic             miss_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            done  <= 1'b0;
            miss  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            done  <= done_d;
            miss  <= miss_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        done_d  = 1'b0;
        miss_d  = 1'b0;
        case (state)
            S_IDLE: begin
                if (trig && (len != '0)) begin
                    state_d = S_HIGH;
                    cnt_d   = len - CNT_ONE;
                end
            end
            S_HIGH: begin
                // A retrigger wins over the exit on the last high cycle.
                if (RETRIG && trig && (len != '0)) begin
                    cnt_d = len - CNT_ONE;
                end else begin
                    miss_d = trig && !RETRIG;
                    if (cnt != '0) begin
                        cnt_d = cnt - CNT_ONE;
                    end else begin
                        done_d = 1'b1;
                        if (gap != '0) begin
                            state_d = S_HOLD;
                            cnt_d   = gap - CNT_ONE;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_HOLD: begin
                miss_d = trig;
                if (cnt != '0) begin
                    cnt_d = cnt - CNT_ONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign out  = (state == S_HIGH);
    assign busy = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pulse_stretch.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_stretch
// Description : Scoreboard bench driving non-retriggering and retriggering
//               instances from one stimulus stream against a timing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_stretch;

    logic       clk;
    logic       rst;
    logic       trig;
    logic [7:0] len;
    logic [7:0] gap;
    logic [1:0] out;
    logic [1:0] busy;
    logic [1:0] done;
    logic [1:0] miss;

    int checks = 0;
    int errors = 0;

    typedef logic [3:0] exp_t;   // {out, busy, done, miss}
    exp_t q0[$];
    exp_t q1[$];

    // Model state: remaining high cycles, remaining holdoff cycles, pending pulses
    int hi_left[2];
    int hold_left[2];
    bit done_c[2];
    bit miss_c[2];

    pulse_stretch #(.CNT_W(8), .RETRIG(1'b0)) dut0 (
        .clk(clk), .rst(rst), .trig(trig), .len(len), .gap(gap),
        .out(out[0]), .busy(busy[0]), .done(done[0]), .miss(miss[0])
    );

    pulse_stretch #(.CNT_W(8), .RETRIG(1'b1)) dut1 (
        .clk(clk), .rst(rst), .trig(trig), .len(len), .gap(gap),
        .out(out[1]), .busy(busy[1]), .done(done[1]), .miss(miss[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string name, input int k, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d @%0t: got out/busy/done/miss=%b expected %b",
                     name, k, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            hi_left[k]   = 0;
            hold_left[k] = 0;
            done_c[k]    = 1'b0;
            miss_c[k]    = 1'b0;
        end
    endtask

    // Push this cycle's expected outputs, then advance by one clock.
    task automatic model_step(input int k, input bit t, input int l, input int g);
        exp_t e;
        bit   rtg;
        bit   dn;
        bit   ms;
        rtg = (k == 1);
        e = {hi_left[k] > 0, (hi_left[k] > 0) || (hold_left[k] > 0), done_c[k], miss_c[k]};
        if (k == 0) q0.push_back(e); else q1.push_back(e);
        dn = 1'b0;
        ms = 1'b0;
        if (hi_left[k] > 0) begin
            if (t && rtg && l != 0) begin
                hi_left[k] = l;
            end else begin
                ms = t && !rtg;
                if (hi_left[k] == 1) begin
                    dn           = 1'b1;
                    hi_left[k]   = 0;
                    hold_left[k] = g;
                end else begin
                    hi_left[k]--;
                end
            end
        end else if (hold_left[k] > 0) begin
            ms = t;
            hold_left[k]--;
        end else if (t && l != 0) begin
            hi_left[k] = l;
        end
        done_c[k] = dn;
        miss_c[k] = ms;
    endtask

    // Called shortly after a rising edge; returns shortly after the next one.
    task automatic step(input bit t, input int l, input int g);
        trig = t;
        len  = l[7:0];
        gap  = g[7:0];
        model_step(0, t, l, g);
        model_step(1, t, l, g);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0);
    endtask

    // Asynchronous reset landing between edges; outputs must drop at once.
    task automatic reset_mid_cycle();
        #2;
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++)
            compare("async_reset", k, {out[k], busy[k], done[k], miss[k]}, 4'b0000);
        q0.delete();
        q1.delete();
        model_reset();
        trig = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (q0.size() > 0) compare("cycle", 0, {out[0], busy[0], done[0], miss[0]}, q0.pop_front());
            if (q1.size() > 0) compare("cycle", 1, {out[1], busy[1], done[1], miss[1]}, q1.pop_front());
        end
    end

    initial begin
        int t, l, g, r;
        rst  = 1'b0;
        trig = 1'b0;
        len  = '0;
        gap  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++)
            compare("reset_state", k, {out[k], busy[k], done[k], miss[k]}, 4'b0000);
        rst = 1'b1;

        // Basic pulse, len=5 gap=0
        step(1'b1, 5, 0);
        idle(8);
        // Overlapping triggers, len=4 gap=3 (miss in HIGH / HOLD, retrigger on inst1)
        step(1'b1, 4, 3); step(1'b0, 4, 3); step(1'b1, 4, 3); step(1'b0, 4, 3);
        step(1'b0, 4, 3); step(1'b0, 4, 3); step(1'b1, 4, 3); step(1'b0, 4, 3);
        step(1'b1, 4, 3);
        idle(12);
        // Repeated retrigger, len=3 gap=0
        step(1'b1, 3, 0); step(1'b0, 3, 0); step(1'b1, 3, 0); step(1'b0, 3, 0);
        step(1'b1, 3, 0);
        idle(8);
        // Trigger on the last high cycle and on the final holdoff cycle
        step(1'b1, 2, 2); step(1'b0, 2, 2); step(1'b1, 2, 2); step(1'b0, 2, 2);
        step(1'b1, 2, 2);
        idle(10);
        // len=0 is dropped, both idle and mid-pulse
        step(1'b1, 0, 3);
        idle(3);
        step(1'b1, 3, 0); step(1'b1, 0, 0);
        idle(5);
        // Reset mid-pulse, then a one-cycle pulse
        step(1'b1, 10, 2); step(1'b0, 10, 2);
        reset_mid_cycle();
        step(1'b1, 1, 0);
        idle(4);
        // Maximum length without wrap
        step(1'b1, 255, 1);
        idle(260);
        // Maximum holdoff
        step(1'b1, 1, 255);
        idle(260);

        for (int i = 0; i < 3000; i++) begin
            t = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 9);
            l = (r == 0) ? 0 : (r == 9) ? $urandom_range(20, 255) : $urandom_range(1, 6);
            r = $urandom_range(0, 9);
            g = (r < 3) ? 0 : (r == 9) ? $urandom_range(10, 40) : $urandom_range(1, 4);
            step(t[0], l, g);
            if (i == 1000 || i == 2200) reset_mid_cycle();
        end
        idle(3);
        @(negedge clk);
        #1;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pulse_stretch.md
PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 The module SHALL have parameter CNT_W, default 8, giving the width of the len, gap and internal counter fields.
REQ-002 The module SHALL have parameter RETRIG, default 0; when set to 1, a trigger during HIGH restarts the high time.
REQ-003 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  SHALL be the reset: asynchronous, active-low (rst=0 resets).
REQ-005 Port trig  input  1  SHALL be the single-cycle request strobe, synchronous to clk.
REQ-006 Port len  input  CNT_W  SHALL give the high time in clk cycles; it is sampled on an accepted trig.
REQ-007 Port gap  input  CNT_W  SHALL give the holdoff time in clk cycles after the high time; it is sampled on the last HIGH cycle.
REQ-008 Port out  output  1  SHALL be the stretched level output.
REQ-009 Port busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-010 Port done  output  1  SHALL be a one-cycle pulse marking the end of a high time.
REQ-011 Port miss  output  1  SHALL be a one-cycle pulse marking an ignored trig.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, HIGH, HOLD.
REQ-013 The FSM SHALL hold one down-counter cnt of width CNT_W.
REQ-014 out SHALL be a Moore output: 1 only in HIGH. busy SHALL be 1 in HIGH and HOLD.
REQ-015 In IDLE with trig=1 and len!=0, the FSM SHALL go to HIGH and load cnt<=len-1.
REQ-016 out SHALL rise on the cycle after trig (latency 1) and SHALL stay high for exactly len cycles.
REQ-017 In IDLE with trig=1 and len=0, the trig SHALL be dropped silently: no state change, miss=0.
REQ-018 In HIGH with cnt!=0, cnt SHALL decrement by 1.
REQ-019 In HIGH with cnt=0 and gap!=0, the FSM SHALL go to HOLD and load cnt<=gap-1.
REQ-020 In HIGH with cnt=0 and gap=0, the FSM SHALL go to IDLE.
REQ-021 done SHALL be registered and SHALL be 1 for exactly the first cycle after the last HIGH cycle, which is the first cycle in which out=0.
REQ-022 In HOLD, cnt SHALL decrement; with cnt=0 the FSM SHALL go to IDLE. busy SHALL stay high for exactly gap cycles after out falls.
REQ-023 With RETRIG=1, trig in HIGH with len!=0 SHALL reload cnt<=len-1, so out stays high until len cycles after the last trig, with no gap in out and no intermediate done.
REQ-024 With RETRIG=1, trig in HIGH with len=0 SHALL be ignored, with miss=0.
REQ-025 With RETRIG=0, trig in HIGH SHALL NOT affect cnt or state and SHALL cause miss=1 on the following cycle.
REQ-026 trig in HOLD, including the final HOLD cycle, SHALL be ignored and SHALL cause miss=1 on the following cycle; no queuing.
REQ-027 trig on the last HIGH cycle (cnt=0):
- RETRIG=1: SHALL retrigger, taking precedence over the exit transition.
- RETRIG=0: SHALL produce a miss.
REQ-028 miss SHALL be registered with latency exactly 1 cycle from the offending trig, one cycle per ignored trig.
REQ-029 cnt SHALL never wrap: a decrement occurs only when cnt!=0, and the maximum len or gap is 2^CNT_W-1 cycles.

Reset
REQ-030 When rst=0, the FSM SHALL go to IDLE immediately, independent of clk.
REQ-031 Reset SHALL set cnt=0, out=0, busy=0, done=0 and miss=0.
REQ-032 Reset asserted mid-HIGH or mid-HOLD SHALL abort the operation with no done pulse.
REQ-033 After rst returns to 1, the first trig on a clk edge SHALL be accepted normally.

Verification
REQ-034 trig at cycle 0 with len=5, gap=0 -> out=1 on cycles 1..5, done=1 on cycle 6, busy=0 on cycle 6.
REQ-035 With RETRIG=0, len=4, gap=3: trig at 0, trig at 2, trig at 6 -> out=1 on 1..4; miss=1 on 3 and 7; done=1 on 5; busy=1 on 1..7; the trig at 8 is accepted and out=1 from 9.
REQ-036 With RETRIG=1, len=3, gap=0: trig at 0, trig at 2, trig at 4 -> out=1 on 1..7 continuously, exactly one done at cycle 8, miss never asserted.
REQ-037 trig with len=0 -> out, busy, done and miss all remain 0.
REQ-038 rst=0 asserted between clock edges at cycle 2 of a len=10 pulse -> out and busy fall immediately, no done; after release, trig with len=1 -> out=1 for one cycle.
REQ-039 CNT_W=8, len=255 -> out high for exactly 255 cycles, with no counter wrap.
